tia_line_fifo: RTL and testbench

//  Parametrised multi-bank scanline buffer between the TIA pixel stream and the VGA scanout.

---
 rtl/atari_av_pkg.sv | 20 ++
 rtl/scanline_ram.sv | 32 +++
 rtl/tia_line_fifo.sv | 175 +++++++++++++++++
 tb/tb_tia_line_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atari_av_pkg.sv
// Shared types and constants for the Atari TIA -> VGA video path.
package atari_av_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    WAIT_VGA = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int TIA_VISIBLE   = 160;
  localparam int TIA_CLOCKS    = 228;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_TOTAL   = 800;

  // Ring successor of a bank index: wraps from nbanks-1 back to 0.
  function automatic int next_bank(input int bank, input int nbanks);
    return (bank + 1 >= nbanks) ? 0 : bank + 1;
  endfunction

endpackage

// File: rtl/scanline_ram.sv
// Scanline storage for all banks: one write port and one registered,
// read-before-write read port. Plain array so it can land in flops or BRAM.
module scanline_ram #(
  parameter int PIXW  = 7,
  parameter int DEPTH = 320,
  parameter int AW    = 9
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [PIXW-1:0] i_wdata,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output logic [PIXW-1:0] o_rdata
);

  logic [PIXW-1:0] r_mem [DEPTH];
  logic [PIXW-1:0] r_rdata;

  // Pixel write from the TIA side.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; a same-address write in this cycle is not yet visible.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tia_line_fifo.sv
// Multi-bank scanline buffer between the TIA pixel stream and VGA scanout.
// The write side fills one bank per TIA line, the read side scans a full
// bank VREPEAT times with horizontal pixel replication, and a lock FSM
// aligns TIA vsync with the VGA frame start. Overflow/underflow are slips.
module tia_line_fifo
  import atari_av_pkg::*;
#(
  parameter int PIXW        = 7,
  parameter int LINE_PIXELS = TIA_VISIBLE,
  parameter int XW          = 8,
  parameter int XSCALE_LOG2 = 2,
  parameter int VREPEAT     = 2,
  parameter int NBANKS      = 2,
  parameter int SLIP_LIMIT  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [XW-1:0]             wr_x_i,
  input  logic [PIXW-1:0]           wr_pix_i,
  input  logic                      wr_eol_i,
  input  logic                      tia_vsync_i,
  input  logic [9:0]                rd_x_i,
  input  logic                      rd_active_i,
  input  logic                      rd_eol_i,
  input  logic                      vga_frame_start_i,
  output logic [PIXW-1:0]           pix_o,
  output logic                      pix_valid_o,
  output logic                      locked_o,
  output logic                      slip_o,
  output logic [$clog2(NBANKS)-1:0] wr_bank_o,
  output logic [$clog2(NBANKS)-1:0] rd_bank_o
);

  localparam int BW    = $clog2(NBANKS);
  localparam int RW    = (VREPEAT > 1) ? $clog2(VREPEAT) : 1;
  localparam int SW    = $clog2(SLIP_LIMIT + 2);
  localparam int DEPTH = NBANKS * LINE_PIXELS;
  localparam int AW    = $clog2(DEPTH);

  lock_state_t       r_state, w_state_nx;
  logic              r_vs_d;
  logic [NBANKS-1:0] r_full, w_full_nx, w_full_rel;
  logic [BW-1:0]     r_wr_bank, r_rd_bank, w_wr_bank_nx, w_rd_bank_nx;
  logic [BW-1:0]     w_wr_next, w_rd_next;
  logic [RW-1:0]     r_rep_cnt, w_rep_cnt_nx;
  logic [SW-1:0]     r_slip_cnt, w_slip_cnt_nx, w_slip_base;
  logic              w_ovf, w_udf, w_vs_rise, w_locked;
  logic              r_pix_valid, r_slip;
  logic [9:0]        w_idx;
  logic              w_idx_ok, w_wr_ok;
  logic [AW-1:0]     w_waddr, w_raddr;
  logic [PIXW-1:0]   w_rdata;

  assign w_locked  = (r_state == LOCKED);
  // r_vs_d resets high so a vsync already high at reset release is not an edge.
  assign w_vs_rise = tia_vsync_i & ~r_vs_d;
  assign w_wr_next = BW'(next_bank(int'(r_wr_bank), NBANKS));
  assign w_rd_next = BW'(next_bank(int'(r_rd_bank), NBANKS));

  assign w_wr_ok  = wr_en_i && (32'(wr_x_i) < LINE_PIXELS);
  assign w_waddr  = AW'(32'(r_wr_bank) * LINE_PIXELS + 32'(wr_x_i));
  assign w_idx    = rd_x_i >> XSCALE_LOG2;
  assign w_idx_ok = (32'(w_idx) < LINE_PIXELS);
  assign w_raddr  = AW'(32'(r_rd_bank) * LINE_PIXELS + 32'(w_idx));

  scanline_ram #(
    .PIXW  (PIXW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_wr_ok),
    .i_waddr (w_waddr),
    .i_wdata (wr_pix_i),
    .i_re    (w_idx_ok),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Lock FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= UNLOCKED;
    else       r_state <= w_state_nx;
  end

  // Lock FSM next state plus bank/flag/repeat/slip bookkeeping.
  always_comb begin
    w_state_nx    = r_state;
    w_full_rel    = r_full;
    w_full_nx     = r_full;
    w_wr_bank_nx  = r_wr_bank;
    w_rd_bank_nx  = r_rd_bank;
    w_rep_cnt_nx  = r_rep_cnt;
    w_slip_cnt_nx = r_slip_cnt;
    w_slip_base   = r_slip_cnt;
    w_ovf         = 1'b0;
    w_udf         = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (w_vs_rise) w_state_nx = WAIT_VGA;
      end
      WAIT_VGA: begin
        if (vga_frame_start_i) begin
          w_state_nx    = LOCKED;
          w_full_nx     = '0;
          w_wr_bank_nx  = '0;
          w_rd_bank_nx  = '0;
          w_rep_cnt_nx  = '0;
          w_slip_cnt_nx = '0;
        end
      end
      LOCKED: begin
        // Read release first, so the write side sees the freed bank.
        if (rd_eol_i) begin
          if (r_rep_cnt != RW'(VREPEAT - 1)) begin
            w_rep_cnt_nx = r_rep_cnt + RW'(1);
          end else if (r_full[w_rd_next]) begin
            w_full_rel[r_rd_bank] = 1'b0;
            w_rd_bank_nx          = w_rd_next;
            w_rep_cnt_nx          = '0;
          end else begin
            w_rep_cnt_nx = '0;
            w_udf        = 1'b1;
          end
        end
        w_full_nx = w_full_rel;
        if (wr_eol_i) begin
          w_full_nx[r_wr_bank] = 1'b1;
          if (!w_full_rel[w_wr_next]) w_wr_bank_nx = w_wr_next;
          else                        w_ovf        = 1'b1;
        end
        // A frame start restarts the slip budget; overflow+underflow count once.
        w_slip_base = vga_frame_start_i ? '0 : r_slip_cnt;
        if ((w_ovf || w_udf) && (w_slip_base <= SW'(SLIP_LIMIT)))
          w_slip_cnt_nx = w_slip_base + SW'(1);
        else
          w_slip_cnt_nx = w_slip_base;
        if (w_slip_cnt_nx > SW'(SLIP_LIMIT)) w_state_nx = UNLOCKED;
      end
      default: w_state_nx = UNLOCKED;
    endcase
  end

  // Bank pointers, full flags, counters, vsync history and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full      <= '0;
      r_wr_bank   <= '0;
      r_rd_bank   <= '0;
      r_rep_cnt   <= '0;
      r_slip_cnt  <= '0;
      r_vs_d      <= 1'b1;
      r_pix_valid <= 1'b0;
      r_slip      <= 1'b0;
    end else begin
      r_full      <= w_full_nx;
      r_wr_bank   <= w_wr_bank_nx;
      r_rd_bank   <= w_rd_bank_nx;
      r_rep_cnt   <= w_rep_cnt_nx;
      r_slip_cnt  <= w_slip_cnt_nx;
      r_vs_d      <= tia_vsync_i;
      r_pix_valid <= w_locked && rd_active_i && w_idx_ok;
      r_slip      <= w_ovf || w_udf;
    end
  end

  assign pix_o       = r_pix_valid ? w_rdata : '0;
  assign pix_valid_o = r_pix_valid;
  assign locked_o    = w_locked;
  assign slip_o      = r_slip;
  assign wr_bank_o   = r_wr_bank;
  assign rd_bank_o   = r_rd_bank;

endmodule

// File: tb/tb_tia_line_fifo.sv
// Testbench for tia_line_fifo: table of directed cycles, hand sequences for
// multi-cycle corner cases, and random traffic against a behavioural model.
module tb_tia_line_fifo;

  localparam int NB = 2;
  localparam int LP = 160;
  localparam int XS = 2;
  localparam int VR = 2;
  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_eol, vsync, rd_active, rd_eol, fs;
  logic [7:0] wr_x;
  logic [6:0] wr_pix;
  logic [9:0] rd_x;
  logic [6:0] pix;
  logic       pix_valid, locked, slip;
  logic [0:0] wr_bank, rd_bank;

  int checks = 0;
  int errors = 0;

  tia_line_fifo #(
    .PIXW(7), .LINE_PIXELS(LP), .XW(8), .XSCALE_LOG2(XS),
    .VREPEAT(VR), .NBANKS(NB), .SLIP_LIMIT(SL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_x_i(wr_x), .wr_pix_i(wr_pix),
    .wr_eol_i(wr_eol), .tia_vsync_i(vsync), .rd_x_i(rd_x), .rd_active_i(rd_active),
    .rd_eol_i(rd_eol), .vga_frame_start_i(fs), .pix_o(pix), .pix_valid_o(pix_valid),
    .locked_o(locked), .slip_o(slip), .wr_bank_o(wr_bank), .rd_bank_o(rd_bank)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int  m_st;            // 0 unlocked, 1 waiting for VGA frame, 2 locked
  bit  m_vs_prev;
  bit  m_full [NB];
  int  m_wr, m_rd, m_rep, m_slip;
  int  mem [NB][LP];
  bit  mk  [NB][LP];
  int  e_pix, e_valid, e_slip, e_locked, e_wrb, e_rdb;
  bit  e_known;

  task automatic model_reset();
    m_st = 0; m_vs_prev = 1'b1;
    m_wr = 0; m_rd = 0; m_rep = 0; m_slip = 0;
    for (int b = 0; b < NB; b++) begin
      m_full[b] = 1'b0;
      for (int x = 0; x < LP; x++) mk[b][x] = 1'b0;
    end
  endtask

  task automatic model_step();
    int idx, nb;
    bit s, rise;
    idx = int'(rd_x) >> XS;
    e_valid = (m_st == 2 && rd_active && idx < LP) ? 1 : 0;
    e_pix = 0; e_known = 1'b1;
    if (e_valid == 1) begin
      e_pix = mem[m_rd][idx];
      e_known = mk[m_rd][idx];
    end
    if (wr_en && int'(wr_x) < LP) begin
      mem[m_wr][wr_x] = int'(wr_pix);
      mk[m_wr][wr_x] = 1'b1;
    end
    rise = vsync && !m_vs_prev;
    m_vs_prev = vsync;
    s = 1'b0;
    if (m_st == 0) begin
      if (rise) m_st = 1;
    end else if (m_st == 1) begin
      if (fs) begin
        m_st = 2; m_wr = 0; m_rd = 0; m_rep = 0; m_slip = 0;
        for (int b = 0; b < NB; b++) m_full[b] = 1'b0;
      end
    end else begin
      if (rd_eol) begin
        if (m_rep < VR - 1) m_rep++;
        else begin
          m_rep = 0;
          nb = (m_rd + 1) % NB;
          if (m_full[nb]) begin m_full[m_rd] = 1'b0; m_rd = nb; end
          else s = 1'b1;
        end
      end
      if (wr_eol) begin
        nb = (m_wr + 1) % NB;
        m_full[m_wr] = 1'b1;
        if (!m_full[nb]) m_wr = nb;
        else s = 1'b1;
      end
      if (fs) m_slip = 0;
      if (s && m_slip <= SL) m_slip++;
      if (m_slip > SL) m_st = 0;
    end
    e_slip = s ? 1 : 0;
    e_locked = (m_st == 2) ? 1 : 0;
    e_wrb = m_wr; e_rdb = m_rd;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    model_step();
    tick();
    chk("m_locked", int'(locked), e_locked);
    chk("m_slip", int'(slip), e_slip);
    chk("m_valid", int'(pix_valid), e_valid);
    chk("m_wr_bank", int'(wr_bank), e_wrb);
    chk("m_rd_bank", int'(rd_bank), e_rdb);
    if (e_known) chk("m_pix", int'(pix), e_pix);
  endtask

  task automatic clear_inputs();
    wr_en = 0; wr_x = '0; wr_pix = '0; wr_eol = 0; vsync = 0;
    rd_x = '0; rd_active = 0; rd_eol = 0; fs = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic lock_seq();
    vsync = 0; cyc();
    vsync = 1; cyc();
    fs = 1; cyc();
    fs = 0;
    chk("lock_seq_locked", int'(locked), 1);
  endtask

  typedef struct {
    bit vs, fs, we, re, act;
    bit lk, sl;
    int wb, rb;
    bit vl;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // directed cycle table: inputs, then outputs after the following edge
    tbl[0]  = '{0,0,0,0,1, 0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,0, 0,0,0,0,0};
    tbl[2]  = '{1,1,0,0,0, 1,0,0,0,0};
    tbl[3]  = '{0,0,0,0,1, 1,0,0,0,1};
    tbl[4]  = '{0,0,1,0,0, 1,0,1,0,0};
    tbl[5]  = '{0,0,1,0,0, 1,1,1,0,0};
    tbl[6]  = '{0,0,1,0,0, 1,1,1,0,0};
    tbl[7]  = '{0,0,0,0,0, 1,0,1,0,0};
    tbl[8]  = '{0,0,0,1,0, 1,0,1,0,0};
    tbl[9]  = '{0,0,0,1,0, 1,0,1,1,0};
    tbl[10] = '{0,0,0,1,0, 1,0,1,1,0};
    tbl[11] = '{0,0,0,1,0, 1,1,1,1,0};
    tbl[12] = '{0,1,0,0,0, 1,0,1,1,0};
    tbl[13] = '{0,0,1,0,0, 1,0,0,1,0};

    rst = 1'b1;
    clear_inputs();
    do_reset();
    chk("rst_locked", int'(locked), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_pix", int'(pix), 0);
    chk("rst_slip", int'(slip), 0);
    chk("rst_wr_bank", int'(wr_bank), 0);
    chk("rst_rd_bank", int'(rd_bank), 0);

    for (int i = 0; i < 14; i++) begin
      vsync = tbl[i].vs; fs = tbl[i].fs; wr_eol = tbl[i].we;
      rd_eol = tbl[i].re; rd_active = tbl[i].act; rd_x = '0;
      tick();
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("tbl%0d_slip", i), int'(slip), int'(tbl[i].sl));
      chk($sformatf("tbl%0d_wr_bank", i), int'(wr_bank), tbl[i].wb);
      chk($sformatf("tbl%0d_rd_bank", i), int'(rd_bank), tbl[i].rb);
      chk($sformatf("tbl%0d_valid", i), int'(pix_valid), int'(tbl[i].vl));
    end

    // full line write then scaled readout, repeated, then underflow repeat
    do_reset();
    lock_seq();
    for (int x = 0; x < LP; x++) begin
      wr_en = 1; wr_x = 8'(x); wr_pix = 7'(x);
      cyc();
    end
    wr_en = 0; wr_eol = 1; cyc(); wr_eol = 0;
    chk("line_wr_bank", int'(wr_bank), 1);
    for (int x = 0; x < 640; x++) begin
      rd_active = 1; rd_x = 10'(x);
      cyc();
      chk("line_valid", int'(pix_valid), 1);
      chk("line_pix", int'(pix), (x >> 2) & 127);
    end
    rd_active = 0;
    rd_eol = 1; cyc(); rd_eol = 0;
    chk("rep1_slip", int'(slip), 0);
    for (int x = 3; x < 640; x += 37) begin
      rd_active = 1; rd_x = 10'(x);
      cyc();
      chk("rep1_pix", int'(pix), (x >> 2) & 127);
    end
    rd_active = 0;
    rd_eol = 1; cyc(); rd_eol = 0;
    chk("udf_slip", int'(slip), 1);
    chk("udf_rd_bank", int'(rd_bank), 0);
    for (int x = 0; x < 640; x += 53) begin
      rd_active = 1; rd_x = 10'(x);
      cyc();
      chk("udf_pix", int'(pix), (x >> 2) & 127);
    end
    rd_active = 0;

    // simultaneous final rd_eol and wr_eol with both banks full
    do_reset();
    lock_seq();
    wr_eol = 1; cyc();
    cyc();
    chk("both_full_ovf", int'(slip), 1);
    wr_eol = 0;
    rd_eol = 1; cyc();
    rd_eol = 1; wr_eol = 1; cyc();
    rd_eol = 0; wr_eol = 0;
    chk("same_clk_slip", int'(slip), 0);
    chk("same_clk_rd_bank", int'(rd_bank), 1);
    chk("same_clk_wr_bank", int'(wr_bank), 0);

    // five underflow slips in one frame drop lock; relock needs vsync rise
    do_reset();
    lock_seq();
    for (int s = 1; s <= 5; s++) begin
      rd_eol = 1; cyc();
      cyc();
      rd_eol = 0;
      chk("slip_n_pulse", int'(slip), 1);
      chk("slip_n_locked", int'(locked), (s < 5) ? 1 : 0);
    end
    cyc();
    fs = 1; cyc(); fs = 0;
    chk("relock_needs_vsync", int'(locked), 0);
    vsync = 0; cyc();
    vsync = 1; cyc();
    fs = 1; cyc(); fs = 0;
    chk("relocked", int'(locked), 1);

    // asynchronous reset in the middle of a displayed line
    rd_active = 1; rd_x = 10'd40;
    cyc();
    chk("pre_rst_valid", int'(pix_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_valid", int'(pix_valid), 0);
    chk("async_rst_pix", int'(pix), 0);
    chk("async_rst_slip", int'(slip), 0);
    do_reset();

    // random traffic against the model
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 119) == 0) vsync = ~vsync;
      fs        = ($urandom_range(0, 149) == 0);
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_x      = 8'($urandom_range(0, 200));
      wr_pix    = 7'($urandom);
      wr_eol    = ($urandom_range(0, 24) == 0);
      rd_eol    = ($urandom_range(0, 14) == 0);
      rd_active = ($urandom_range(0, 3) != 0);
      rd_x      = 10'($urandom_range(0, 700));
      cyc();
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
